// File: rtl/rtc_bus_sched_if.sv
// ---------------------------------------------------------------------------
// rtc_bus_sched_if
// Groups the request/done handshakes, the per-FSM bus strobes and the muxed
// RTC pins that connect to the RTC bus scheduler.
//   esc_req, init_req               : one-cycle transaction requests
//   init_done, esc_done, lect_done  : one-cycle completion pulses from the FSMs
//   init_bus, esc_bus, lect_bus     : {a_d, cs, rd, wr} from each FSM
//   go_init, go_esc, go_lect        : one-cycle start pulses to the FSMs
//   a_d, cs, rd, wr                 : muxed RTC pins (cs/rd/wr active-low)
//   grant                           : 0 none, 1 init, 2 esc, 3 lect
//   busy                            : scheduler not idle
//   timeout_err                     : one-cycle pulse on watchdog expiry
// Modport slave is the scheduler side; master is the side around it.
// ---------------------------------------------------------------------------
interface rtc_bus_sched_if;
    logic       esc_req;
    logic       init_req;
    logic       init_done;
    logic       esc_done;
    logic       lect_done;
    logic [3:0] init_bus;
    logic [3:0] esc_bus;
    logic [3:0] lect_bus;
    logic       go_init;
    logic       go_esc;
    logic       go_lect;
    logic       a_d;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [1:0] grant;
    logic       busy;
    logic       timeout_err;

    modport slave (
        input  esc_req, init_req, init_done, esc_done, lect_done,
        input  init_bus, esc_bus, lect_bus,
        output go_init, go_esc, go_lect,
        output a_d, cs, rd, wr,
        output grant, busy, timeout_err
    );

    modport master (
        output esc_req, init_req, init_done, esc_done, lect_done,
        output init_bus, esc_bus, lect_bus,
        input  go_init, go_esc, go_lect,
        input  a_d, cs, rd, wr,
        input  grant, busy, timeout_err
    );
endinterface

// File: rtl/rtc_bus_sched.sv
// ---------------------------------------------------------------------------
// rtc_bus_sched
// Arbiter for the shared RTC parallel bus. Three transaction FSMs (init,
// write/escritura, periodic read/lectura) are launched one at a time with a
// one-cycle go pulse; the granted FSM's {a_d,cs,rd,wr} is muxed onto the pins,
// an idle gap follows every transaction and a watchdog releases a grant that
// never reports done.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low
//   sif    : rtc_bus_sched_if.slave (requests, dones, FSM buses, go pulses,
//            muxed pins, grant, busy, timeout_err)
// Parameters:
//   READ_PERIOD : cycles between automatic read requests (>= 2)
//   GAP_CYC     : idle-bus cycles after each transaction (>= 1)
//   TIMEOUT     : longest allowed grant before forced release
// ---------------------------------------------------------------------------
module rtc_bus_sched #(
    parameter int READ_PERIOD = 100000,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT     = 4096
) (
    input  logic              clk,
    input  logic              reset,
    rtc_bus_sched_if.slave    sif
);

    localparam int RD_W  = $clog2(READ_PERIOD);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_G_INIT,
        S_G_ESC,
        S_G_LECT,
        S_GAP
    } state_t;

    state_t             state_reg, state_next;
    logic [RD_W-1:0]    rd_cnt_reg, rd_cnt_next;
    logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
    logic [WD_W-1:0]    wd_cnt_reg, wd_cnt_next;
    logic               init_pend_reg, init_pend_next;
    logic               esc_pend_reg, esc_pend_next;
    logic               lect_pend_reg, lect_pend_next;
    logic               go_init_reg, go_init_next;
    logic               go_esc_reg, go_esc_next;
    logic               go_lect_reg, go_lect_next;
    logic [1:0]         grant_reg, grant_next;
    logic               busy_reg, busy_next;
    logic               timeout_err_reg, timeout_err_next;

    logic               rd_tc;
    logic               clr_init, clr_esc, clr_lect;
    logic               owner_done;
    logic [3:0]         pins;

    // Free-running read period counter
    assign rd_tc       = (rd_cnt_reg == RD_W'(READ_PERIOD - 1));
    assign rd_cnt_next = rd_tc ? '0 : rd_cnt_reg + RD_W'(1);

    // Only the granted FSM's done is looked at; the others are ignored
    always_comb begin
        owner_done = 1'b0;
        case (state_reg)
            S_G_INIT: owner_done = sif.init_done;
            S_G_ESC:  owner_done = sif.esc_done;
            S_G_LECT: owner_done = sif.lect_done;
            default:  owner_done = 1'b0;
        endcase
    end

    always_comb begin
        state_next       = state_reg;
        gap_cnt_next     = gap_cnt_reg;
        wd_cnt_next      = wd_cnt_reg;
        clr_init         = 1'b0;
        clr_esc          = 1'b0;
        clr_lect         = 1'b0;
        timeout_err_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                wd_cnt_next = '0;
                // Fixed priority init > esc > lect; flag consumed at grant start
                if (init_pend_reg) begin
                    state_next = S_G_INIT;
                    clr_init   = 1'b1;
                end else if (esc_pend_reg) begin
                    state_next = S_G_ESC;
                    clr_esc    = 1'b1;
                end else if (lect_pend_reg) begin
                    state_next = S_G_LECT;
                    clr_lect   = 1'b1;
                end
            end
            S_G_INIT, S_G_ESC, S_G_LECT: begin
                if (owner_done) begin
                    state_next   = S_GAP;
                    gap_cnt_next = '0;
                end else if (wd_cnt_reg == WD_W'(TIMEOUT - 1)) begin
                    // Hung FSM: release the bus and drop its request for good
                    state_next       = S_GAP;
                    gap_cnt_next     = '0;
                    timeout_err_next = 1'b1;
                    clr_init         = (state_reg == S_G_INIT);
                    clr_esc          = (state_reg == S_G_ESC);
                    clr_lect         = (state_reg == S_G_LECT);
                end else begin
                    wd_cnt_next = wd_cnt_reg + WD_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_reg == GAP_W'(GAP_CYC - 1)) begin
                    state_next = S_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // A set arriving together with a clear wins, so the new request is kept
    assign init_pend_next = sif.init_req | (init_pend_reg & ~clr_init);
    assign esc_pend_next  = sif.esc_req  | (esc_pend_reg  & ~clr_esc);
    assign lect_pend_next = rd_tc        | (lect_pend_reg & ~clr_lect);

    // Registered outputs are decoded from the next state so they line up with it
    always_comb begin
        go_init_next = (state_reg == S_IDLE) && (state_next == S_G_INIT);
        go_esc_next  = (state_reg == S_IDLE) && (state_next == S_G_ESC);
        go_lect_next = (state_reg == S_IDLE) && (state_next == S_G_LECT);
        busy_next    = (state_next != S_IDLE);
        case (state_next)
            S_G_INIT: grant_next = 2'd1;
            S_G_ESC:  grant_next = 2'd2;
            S_G_LECT: grant_next = 2'd3;
            default:  grant_next = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= S_IDLE;
            rd_cnt_reg      <= '0;
            gap_cnt_reg     <= '0;
            wd_cnt_reg      <= '0;
            init_pend_reg   <= 1'b1;
            esc_pend_reg    <= 1'b0;
            lect_pend_reg   <= 1'b0;
            go_init_reg     <= 1'b0;
            go_esc_reg      <= 1'b0;
            go_lect_reg     <= 1'b0;
            grant_reg       <= 2'd0;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            rd_cnt_reg      <= rd_cnt_next;
            gap_cnt_reg     <= gap_cnt_next;
            wd_cnt_reg      <= wd_cnt_next;
            init_pend_reg   <= init_pend_next;
            esc_pend_reg    <= esc_pend_next;
            lect_pend_reg   <= lect_pend_next;
            go_init_reg     <= go_init_next;
            go_esc_reg      <= go_esc_next;
            go_lect_reg     <= go_lect_next;
            grant_reg       <= grant_next;
            busy_reg        <= busy_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    // Pin mux is combinational from the state register, so an asynchronous
    // reset idles the bus without waiting for a clock edge
    always_comb begin
        pins = 4'b1111;
        case (state_reg)
            S_G_INIT: pins = sif.init_bus;
            S_G_ESC:  pins = sif.esc_bus;
            S_G_LECT: pins = sif.lect_bus;
            default:  pins = 4'b1111;
        endcase
    end

    assign sif.a_d         = pins[3];
    assign sif.cs          = pins[2];
    assign sif.rd          = pins[1];
    assign sif.wr          = pins[0];
    assign sif.go_init     = go_init_reg;
    assign sif.go_esc      = go_esc_reg;
    assign sif.go_lect     = go_lect_reg;
    assign sif.grant       = grant_reg;
    assign sif.busy        = busy_reg;
    assign sif.timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_rtc_bus_sched.sv
// ---------------------------------------------------------------------------
// tb_rtc_bus_sched
// Self-checking bench for rtc_bus_sched with READ_PERIOD=50, GAP_CYC=4,
// TIMEOUT=16. A transaction-level reference model (owner, age, gap left,
// pending set, period tick) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_rtc_bus_sched;

    localparam int RP  = 50;
    localparam int GAP = 4;
    localparam int TO  = 16;

    logic clk;
    logic reset;

    rtc_bus_sched_if sif();

    rtc_bus_sched #(
        .READ_PERIOD (RP),
        .GAP_CYC     (GAP),
        .TIMEOUT     (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_owner;       // 0 none, 1 init, 2 esc, 3 lect
    int m_age;         // cycles spent in the current grant
    int m_gap_left;    // remaining idle-gap cycles
    int m_tick;        // position within the read period
    int m_go;          // which FSM got a start pulse this cycle
    bit m_to;
    bit m_pend [1:3];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner    = 0;
        m_age      = 0;
        m_gap_left = 0;
        m_tick     = 0;
        m_go       = 0;
        m_to       = 1'b0;
        m_pend[1]  = 1'b1;
        m_pend[2]  = 1'b0;
        m_pend[3]  = 1'b0;
    endtask

    task automatic model_advance();
        bit terminal;
        bit set_f [1:3];
        int clr;
        bit done_f;
        terminal = (m_tick == RP - 1);
        m_tick   = terminal ? 0 : m_tick + 1;
        set_f[1] = sif.init_req;
        set_f[2] = sif.esc_req;
        set_f[3] = terminal;
        clr  = 0;
        m_go = 0;
        m_to = 1'b0;
        if (m_owner != 0) begin
            done_f = (m_owner == 1) ? sif.init_done :
                     (m_owner == 2) ? sif.esc_done  : sif.lect_done;
            if (done_f) begin
                m_owner    = 0;
                m_gap_left = GAP;
            end else if (m_age == TO) begin
                clr        = m_owner;
                m_owner    = 0;
                m_gap_left = GAP;
                m_to       = 1'b1;
            end else begin
                m_age++;
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else begin
            if (m_pend[1])      m_owner = 1;
            else if (m_pend[2]) m_owner = 2;
            else if (m_pend[3]) m_owner = 3;
            if (m_owner != 0) begin
                m_go  = m_owner;
                m_age = 1;
                clr   = m_owner;
            end
        end
        for (int i = 1; i <= 3; i++)
            m_pend[i] = set_f[i] | (m_pend[i] && (clr != i));
    endtask

    function automatic logic [3:0] pins_now();
        return {sif.a_d, sif.cs, sif.rd, sif.wr};
    endfunction

    task automatic check_model();
        logic [3:0]  exp_pins;
        logic [15:0] got_v, exp_v;
        case (m_owner)
            1:       exp_pins = sif.init_bus;
            2:       exp_pins = sif.esc_bus;
            3:       exp_pins = sif.lect_bus;
            default: exp_pins = 4'hF;
        endcase
        exp_v = {5'd0, m_go == 1, m_go == 2, m_go == 3, 2'(m_owner),
                 (m_owner != 0) || (m_gap_left > 0), m_to, exp_pins};
        got_v = {5'd0, sif.go_init, sif.go_esc, sif.go_lect, sif.grant,
                 sif.busy, sif.timeout_err, pins_now()};
        chk("model_cycle", got_v, exp_v);
    endtask

    // One clock: model steps with the inputs present before the edge,
    // outputs are compared on the following falling edge
    task automatic cycle();
        if (!reset) model_reset();
        else        model_advance();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    function automatic bit model_quiet();
        return (m_owner == 0) && (m_gap_left == 0) && !m_pend[1] && !m_pend[2] && !m_pend[3];
    endfunction

    typedef struct {
        logic       init_done;
        logic [3:0] init_bus;
        logic       exp_go_init;
        logic [1:0] exp_grant;
        logic       exp_busy;
        logic [3:0] exp_pins;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int n;
        int gos;

        // Power-up sequence: init granted, done after 10 cycles, 4-cycle gap
        vecs[0]  = '{1'b0, 4'b0101, 1'b1, 2'd1, 1'b1, 4'b0101};
        vecs[1]  = '{1'b0, 4'b0011, 1'b0, 2'd1, 1'b1, 4'b0011};
        vecs[2]  = '{1'b0, 4'b0110, 1'b0, 2'd1, 1'b1, 4'b0110};
        vecs[3]  = '{1'b0, 4'b1001, 1'b0, 2'd1, 1'b1, 4'b1001};
        vecs[4]  = '{1'b0, 4'b0000, 1'b0, 2'd1, 1'b1, 4'b0000};
        vecs[5]  = '{1'b0, 4'b1010, 1'b0, 2'd1, 1'b1, 4'b1010};
        vecs[6]  = '{1'b0, 4'b1100, 1'b0, 2'd1, 1'b1, 4'b1100};
        vecs[7]  = '{1'b0, 4'b0111, 1'b0, 2'd1, 1'b1, 4'b0111};
        vecs[8]  = '{1'b0, 4'b0001, 1'b0, 2'd1, 1'b1, 4'b0001};
        vecs[9]  = '{1'b0, 4'b1110, 1'b0, 2'd1, 1'b1, 4'b1110};
        vecs[10] = '{1'b1, 4'b0010, 1'b0, 2'd0, 1'b1, 4'b1111};
        vecs[11] = '{1'b0, 4'b0100, 1'b0, 2'd0, 1'b1, 4'b1111};
        vecs[12] = '{1'b0, 4'b0100, 1'b0, 2'd0, 1'b1, 4'b1111};
        vecs[13] = '{1'b0, 4'b0100, 1'b0, 2'd0, 1'b1, 4'b1111};
        vecs[14] = '{1'b0, 4'b0100, 1'b0, 2'd0, 1'b0, 4'b1111};
        vecs[15] = '{1'b0, 4'b0100, 1'b0, 2'd0, 1'b0, 4'b1111};

        reset         = 1'b0;
        sif.esc_req   = 1'b0;
        sif.init_req  = 1'b0;
        sif.init_done = 1'b0;
        sif.esc_done  = 1'b0;
        sif.lect_done = 1'b0;
        sif.init_bus  = 4'hF;
        sif.esc_bus   = 4'h3;
        sif.lect_bus  = 4'h5;
        model_reset();

        // Reset state
        repeat (3) cycle();
        chk("reset_outputs", {8'd0, sif.go_init, sif.go_esc, sif.go_lect, sif.grant, sif.busy, sif.timeout_err, 1'b0},
            16'h0000);
        chk("reset_pins", {12'd0, pins_now()}, 16'h000F);

        // Table-driven power-up sequence
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sif.init_done = vecs[i].init_done;
            sif.init_bus  = vecs[i].init_bus;
            sif.esc_bus   = 4'($urandom);
            sif.lect_bus  = 4'($urandom);
            cycle();
            chk($sformatf("vec%0d_go_init", i), {15'd0, sif.go_init}, {15'd0, vecs[i].exp_go_init});
            chk($sformatf("vec%0d_grant", i), {14'd0, sif.grant}, {14'd0, vecs[i].exp_grant});
            chk($sformatf("vec%0d_busy", i), {15'd0, sif.busy}, {15'd0, vecs[i].exp_busy});
            chk($sformatf("vec%0d_pins", i), {12'd0, pins_now()}, {12'd0, vecs[i].exp_pins});
        end

        // esc request and read terminal count land in the same idle cycle
        sif.init_done = 1'b1;
        sif.lect_done = 1'b1;
        n = 0;
        while (!(model_quiet() && m_tick == RP - 1) && n < 300) begin
            cycle();
            n++;
        end
        chk("align_esc_lect_bound", {15'd0, n < 300}, 16'd1);
        sif.esc_req = 1'b1;
        cycle();
        sif.esc_req = 1'b0;
        cycle();
        chk("esc_before_lect_grant", {14'd0, sif.grant}, 16'd2);
        chk("esc_before_lect_go", {15'd0, sif.go_esc}, 16'd1);
        sif.esc_done = 1'b1;
        cycle();
        sif.esc_done = 1'b0;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (sif.go_lect) begin
                n = k;
                break;
            end
        end
        chk("lect_after_esc_gap", n[15:0], 16'(GAP + 1));

        // Second esc request arriving during an esc grant
        n = 0;
        while (!model_quiet() && n < 100) begin
            cycle();
            n++;
        end
        sif.esc_req = 1'b1;
        cycle();
        sif.esc_req = 1'b0;
        cycle();
        chk("esc_first_go", {15'd0, sif.go_esc}, 16'd1);
        sif.esc_req = 1'b1;
        cycle();
        sif.esc_req  = 1'b0;
        sif.esc_done = 1'b1;
        cycle();
        sif.esc_done = 1'b0;
        gos = 0;
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (sif.go_esc) gos++;
        end
        chk("esc_requeued_once", gos[15:0], 16'd1);
        sif.esc_done = 1'b1;
        repeat (2) cycle();

        // Watchdog on a write FSM that never finishes
        sif.esc_done = 1'b0;
        n = 0;
        while (!model_quiet() && n < 100) begin
            cycle();
            n++;
        end
        sif.esc_req = 1'b1;
        cycle();
        sif.esc_req = 1'b0;
        cycle();
        chk("wd_go_esc", {15'd0, sif.go_esc}, 16'd1);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (sif.timeout_err) begin
                n = k;
                break;
            end
        end
        chk("wd_timeout_delay", n[15:0], 16'(TO));
        chk("wd_pins_idle", {12'd0, pins_now()}, 16'h000F);
        gos = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (sif.go_esc) gos++;
        end
        chk("wd_no_regrant", gos[15:0], 16'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 2500; k++) begin
            sif.esc_req   = ($urandom_range(39) == 0);
            sif.init_req  = ($urandom_range(199) == 0);
            sif.init_done = ($urandom_range(7) == 0);
            sif.esc_done  = ($urandom_range(7) == 0);
            sif.lect_done = ($urandom_range(7) == 0);
            sif.init_bus  = 4'($urandom);
            sif.esc_bus   = 4'($urandom);
            sif.lect_bus  = 4'($urandom);
            cycle();
        end

        // Reset pulled low in the middle of a read grant
        sif.esc_req   = 1'b0;
        sif.init_req  = 1'b0;
        sif.init_done = 1'b1;
        sif.esc_done  = 1'b1;
        sif.lect_done = 1'b0;
        n = 0;
        while (sif.grant != 2'd3 && n < 300) begin
            cycle();
            n++;
        end
        chk("mid_lect_reached", {14'd0, sif.grant}, 16'd3);
        sif.lect_bus = 4'b0000;
        #1;
        chk("mid_lect_pins", {12'd0, pins_now()}, 16'h0000);
        reset = 1'b0;
        #1;
        chk("async_reset_pins", {12'd0, pins_now()}, 16'h000F);
        chk("async_reset_grant", {14'd0, sif.grant}, 16'd0);
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        chk("post_reset_go_init", {15'd0, sif.go_init}, 16'd1);
        chk("post_reset_no_lect", {15'd0, sif.go_lect}, 16'd0);
        repeat (10) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
